ram_arbiter: RTL and testbench

//  Shares the SoC's single-port unified RAM (ram_inst) between the core's instruction-fetch

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_if.sv | 52 +++++
 rtl/ram_arbiter_prio.sv | 59 +++++
 rtl/ram_arbiter.sv | 98 +++++++++
 tb/tb_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and default widths for the RAM arbiter slice.
//   owner_e     : which requester owns the access issued in the previous cycle
//   *_DEF       : default address / data widths and starvation limit
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the fetch port, the load/store port and the RAM port.
//   modport slave  : arbiter view (requests in, responses and RAM strobes out)
//   modport master : environment view (core ports + RAM model)
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  // instruction fetch port
  logic                if_req_valid;
  logic                if_req_ready;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_resp_valid;
  logic [DATA_W-1:0]   if_rdata;

  // load/store port
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  // single-port RAM
  logic                ram_ce;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_wstrb;
  logic [DATA_W-1:0]   ram_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    output ram_ce, ram_we, ram_addr, ram_wdata, ram_wstrb,
    input  ram_rdata
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    input  ram_ce, ram_we, ram_addr, ram_wdata, ram_wstrb,
    output ram_rdata
  );

endinterface

// File: rtl/ram_arbiter_prio.sv
// ram_arbiter_prio: fixed MEM > IF priority with a starvation guard for IF.
//   clk, rst   : clock, asynchronous active-low reset
//   if_valid   : fetch request pending
//   mem_valid  : load/store request pending
//   grant_if   : fetch wins this cycle
//   grant_mem  : load/store wins this cycle
// Both grants are forced low while rst is asserted.
module ram_arbiter_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic mem_valid,
  output logic grant_if,
  output logic grant_mem
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_s;
  logic             forced_s;

  // grant select and next starvation count
  always_comb begin
    forced_s     = 1'b0;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;
    starve_cnt_s = starve_cnt_r;
    if (rst) begin
      forced_s  = (starve_cnt_r == CNT_MAX) && if_valid;
      grant_if  = forced_s || (if_valid && !mem_valid);
      grant_mem = mem_valid && !forced_s;
      // The count only tracks MEM wins over a waiting IF; any IF win or an
      // idle IF restarts it, and it saturates at the limit.
      if (!if_valid || grant_if) begin
        starve_cnt_s = {CNT_W{1'b0}};
      end else if (grant_mem && (starve_cnt_r != CNT_MAX)) begin
        starve_cnt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        starve_cnt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_s = {CNT_W{1'b0}};
    end
  end

  // starvation counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_s;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the fetch and load/store ports.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ram_arbiter_if.slave carrying IF, MEM and RAM signals
// One access is issued per cycle; its response appears the following cycle,
// routed by the owner register. Reads return ram_rdata, stores return 0.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic            clk,
  input logic            rst,
  ram_arbiter_if.slave   bus
);

  logic   grant_if_s;
  logic   grant_mem_s;
  owner_e owner_r;
  owner_e owner_s;
  logic   we_q_r;

  ram_arbiter_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (bus.if_req_valid),
    .mem_valid (bus.mem_req_valid),
    .grant_if  (grant_if_s),
    .grant_mem (grant_mem_s)
  );

  // RAM request mux and next owner from the current winner
  always_comb begin
    bus.if_req_ready  = grant_if_s;
    bus.mem_req_ready = grant_mem_s;
    bus.ram_ce        = 1'b0;
    bus.ram_we        = 1'b0;
    bus.ram_addr      = {ADDR_W{1'b0}};
    bus.ram_wdata     = {DATA_W{1'b0}};
    bus.ram_wstrb     = {(DATA_W/8){1'b0}};
    owner_s           = OWN_NONE;
    if (grant_mem_s) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = bus.mem_we;
      bus.ram_addr  = bus.mem_addr;
      bus.ram_wdata = bus.mem_wdata;
      bus.ram_wstrb = bus.mem_wstrb;
      owner_s       = OWN_MEM;
    end else if (grant_if_s) begin
      bus.ram_ce   = 1'b1;
      bus.ram_addr = bus.if_addr;
      owner_s      = OWN_IF;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // owner / write-flag register for the access issued this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r <= OWN_NONE;
      we_q_r  <= 1'b0;
    end else begin
      owner_r <= owner_s;
      we_q_r  <= grant_mem_s & bus.mem_we;
    end
  end

  // response routing to the owner of last cycle's access
  always_comb begin
    bus.if_resp_valid  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.if_rdata       = {DATA_W{1'b0}};
    bus.mem_rdata      = {DATA_W{1'b0}};
    case (owner_r)
      OWN_IF: begin
        bus.if_resp_valid = 1'b1;
        bus.if_rdata      = bus.ram_rdata;
      end
      OWN_MEM: begin
        bus.mem_resp_valid = 1'b1;
        if (!we_q_r) begin
          bus.mem_rdata = bus.ram_rdata;
        end else begin
          bus.mem_rdata = {DATA_W{1'b0}};
        end
      end
      default: begin
        bus.if_resp_valid  = 1'b0;
        bus.mem_resp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + randomized bench for ram_arbiter with a RAM model
// and a scoreboard built from the arbitration rules.
module tb_ram_arbiter;

  localparam int STARVE_MAX = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ram_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ram_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: 256 words, 1-cycle read latency
  logic [63:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 8; b++) begin
          if (bus.ram_wstrb[b]) ram_mem[bus.ram_addr[10:3]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
      end else begin
        bus.ram_rdata <= ram_mem[bus.ram_addr[10:3]];
      end
    end
  end

  // reference model state
  logic [63:0] ref_mem [0:255];
  int          m_cnt;
  logic        exp_if_v, exp_mem_v;
  logic [63:0] exp_if_d, exp_mem_d;
  logic        last_g_if, last_g_mem;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] k;
    k = i;
    return {32'hA5A5_0000 | k, 32'hC3C3_0000 | k};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, advance the model,
  // then return #1 after the following posedge.
  task automatic cycle();
    logic g_if, g_mem;
    logic [7:0] ix;
    @(negedge clk);
    g_if = 1'b0;
    g_mem = 1'b0;
    if (rst) begin
      if (m_cnt == STARVE_MAX && bus.if_req_valid) g_if = 1'b1;
      else if (bus.mem_req_valid) g_mem = 1'b1;
      else if (bus.if_req_valid) g_if = 1'b1;
    end
    chk("if_req_ready", {63'd0, bus.if_req_ready}, {63'd0, g_if});
    chk("mem_req_ready", {63'd0, bus.mem_req_ready}, {63'd0, g_mem});
    chk("ram_ce", {63'd0, bus.ram_ce}, {63'd0, g_if | g_mem});
    if (g_mem) begin
      chk("ram_we_mem", {63'd0, bus.ram_we}, {63'd0, bus.mem_we});
      chk("ram_addr_mem", {32'd0, bus.ram_addr}, {32'd0, bus.mem_addr});
      chk("ram_wdata_mem", bus.ram_wdata, bus.mem_wdata);
      chk("ram_wstrb_mem", {56'd0, bus.ram_wstrb}, {56'd0, bus.mem_wstrb});
    end else if (g_if) begin
      chk("ram_we_if", {63'd0, bus.ram_we}, 64'd0);
      chk("ram_addr_if", {32'd0, bus.ram_addr}, {32'd0, bus.if_addr});
      chk("ram_wstrb_if", {56'd0, bus.ram_wstrb}, 64'd0);
    end else begin
      chk("ram_we_idle", {63'd0, bus.ram_we}, 64'd0);
      chk("ram_addr_idle", {32'd0, bus.ram_addr}, 64'd0);
    end
    chk("if_resp_valid", {63'd0, bus.if_resp_valid}, {63'd0, exp_if_v & rst});
    chk("if_rdata", bus.if_rdata, (exp_if_v & rst) ? exp_if_d : 64'd0);
    chk("mem_resp_valid", {63'd0, bus.mem_resp_valid}, {63'd0, exp_mem_v & rst});
    chk("mem_rdata", bus.mem_rdata, (exp_mem_v & rst) ? exp_mem_d : 64'd0);
    // advance the model
    exp_if_v  = g_if;
    exp_mem_v = g_mem;
    exp_if_d  = 64'd0;
    exp_mem_d = 64'd0;
    if (g_if) begin
      ix = bus.if_addr[10:3];
      exp_if_d = ref_mem[ix];
    end
    if (g_mem) begin
      ix = bus.mem_addr[10:3];
      if (bus.mem_we) begin
        for (int b = 0; b < 8; b++) begin
          if (bus.mem_wstrb[b]) ref_mem[ix][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end
      end else begin
        exp_mem_d = ref_mem[ix];
      end
    end
    if (!rst || !bus.if_req_valid || g_if) m_cnt = 0;
    else if (g_mem && m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
    last_g_if  = g_if;
    last_g_mem = g_mem;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_addr       = 32'd0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = 32'd0;
    bus.mem_wdata     = 64'd0;
    bus.mem_wstrb     = 8'd0;
  endtask

  initial begin
    logic [6:0]  starve_pat;
    logic [63:0] w;
    int          sent;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.ram_rdata = 64'd0;
    m_cnt = 0;
    exp_if_v = 1'b0; exp_mem_v = 1'b0;
    exp_if_d = 64'd0; exp_mem_d = 64'd0;
    last_g_if = 1'b0; last_g_mem = 1'b0;
    idle_inputs();

    // reset: outputs quiet even with requests pending
    #1;
    bus.if_req_valid  = 1'b1;
    bus.mem_req_valid = 1'b1;
    cycle();
    cycle();
    chk("rst_if_resp", {63'd0, bus.if_resp_valid}, 64'd0);
    idle_inputs();
    rst = 1'b1;
    cycle();

    // IF-only stream: three consecutive fetches, no bubbles
    for (int i = 0; i < 3; i++) begin
      bus.if_req_valid = 1'b1;
      bus.if_addr      = BASE + 32'(i * 8);
      cycle();
      chk("if_stream_ready", {63'd0, last_g_if}, 64'd1);
      chk("if_stream_data", bus.if_rdata, init_word(i));
    end
    idle_inputs();
    cycle();

    // starvation guard: 6 MEM loads against a waiting IF -> M,M,M,M,I,M,M
    starve_pat = 7'b1101111;
    sent = 0;
    bus.if_req_valid = 1'b1;
    bus.if_addr      = BASE + 32'h40;
    for (int k = 0; k < 7; k++) begin
      bus.mem_req_valid = (sent < 6);
      bus.mem_addr      = BASE + 32'h200 + 32'(sent * 8);
      cycle();
      chk("starve_seq", {63'd0, last_g_mem}, {63'd0, starve_pat[k]});
      if (last_g_mem) sent++;
      if (last_g_if) begin
        bus.if_req_valid = 1'b0;
        chk("starve_if_resp_k", 64'(k), 64'd4);
        chk("starve_if_data", bus.if_rdata, init_word(8));
      end
    end
    idle_inputs();
    cycle();

    // store then load of the same word, low four bytes written
    bus.mem_req_valid = 1'b1;
    bus.mem_we        = 1'b1;
    bus.mem_addr      = BASE + 32'h100;
    bus.mem_wdata     = 64'h1122334455667788;
    bus.mem_wstrb     = 8'h0F;
    cycle();
    chk("store_ack_valid", {63'd0, bus.mem_resp_valid}, 64'd1);
    chk("store_ack_rdata", bus.mem_rdata, 64'd0);
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 64'd0;
    bus.mem_wstrb = 8'd0;
    cycle();
    w = init_word(32);
    chk("load_after_store", bus.mem_rdata, {w[63:32], 32'h55667788});
    idle_inputs();
    cycle();

    // alternating IF / MEM requests, then idle
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin
        bus.if_req_valid = 1'b1;
        bus.if_addr      = BASE + 32'(k * 24);
      end else begin
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = BASE + 32'(k * 40);
      end
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();
    chk("idle_ram_ce", {63'd0, bus.ram_ce}, 64'd0);
    chk("idle_resp", {62'd0, bus.if_resp_valid, bus.mem_resp_valid}, 64'd0);

    // reset right after a MEM load issue, with starvation count built up
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = BASE + 32'h18;
    bus.mem_req_valid = 1'b1;
    bus.mem_addr      = BASE + 32'h30;
    for (int k = 0; k < 3; k++) cycle();
    rst = 1'b0;
    #1;
    chk("rst_drop_mem_resp", {63'd0, bus.mem_resp_valid}, 64'd0);
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_no_late_resp", {63'd0, bus.mem_resp_valid}, 64'd0);
    bus.mem_req_valid = 1'b1;
    bus.mem_addr      = BASE + 32'h30;
    bus.if_req_valid  = 1'b1;
    bus.if_addr       = BASE + 32'h18;
    starve_pat = 7'b0001111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rst_restart_seq", {63'd0, last_g_mem}, {63'd0, starve_pat[k]});
      if (k == 0) chk("reissue_load", bus.mem_rdata, init_word(6));
    end
    idle_inputs();
    cycle();

    // random valid/hold traffic against the model
    for (int n = 0; n < 10000; n++) begin
      if (!(bus.if_req_valid && !last_g_if)) begin
        bus.if_req_valid = ($urandom_range(0, 99) < 60);
        bus.if_addr      = BASE + {21'd0, 8'($urandom_range(0, 255)), 3'd0};
      end
      if (!(bus.mem_req_valid && !last_g_mem)) begin
        bus.mem_req_valid = ($urandom_range(0, 99) < 55);
        bus.mem_we        = $urandom_range(0, 1);
        bus.mem_addr      = BASE + {21'd0, 8'($urandom_range(0, 255)), 3'd0};
        bus.mem_wdata     = {$urandom, $urandom};
        bus.mem_wstrb     = 8'($urandom_range(0, 255));
      end
      cycle();
    end
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
